wb_burst_reader: RTL and testbench
==================================

# wb_burst_reader

Wishbone B3 bus master that fetches a block of 32-bit words using linear incrementing bursts and delivers them on a valid/ready stream. It sits between a boot/copy engine (or DMA front end) and the system Wishbone bus. It drives the same CTI/BTE burst protocol that the on-chip ROM and RAM slaves terminate. An internal FIFO absorbs each whole burst, so the master never stalls STB mid-burst.

## Interface
- addr_width, 32: Wishbone byte-address width; word address is wb_adr_o[addr_width-1:2], bits [1:0] always 0.
- len_width, 16: width of the word-count field in a command.
- burst_len, 4: maximum beats per burst; power of two, 1..16.
- fifo_depth, 8: output FIFO depth in words; power of two, must be ≥ burst_len.

Ports:
- wb_clk  in  1  system clock; all logic on the rising edge.
- wb_rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid & cmd_ready.
- cmd_adr  in  addr_width  start byte address; bits [1:0] ignored.
- cmd_len  in  len_width  number of words to read; 0 is legal.
- dat_valid  out  1  stream word available (FIFO non-empty).
- dat_ready  in  1  consumer accepts the word.
- dat_o  out  32  stream data (FIFO head).
- dat_last  out  1  high with the final word of a command.
- busy  out  1  command in progress, from accept until the last bus beat completes or errors.
- err  out  1  sticky bus-error flag; cleared on next command accept.
- wb_adr_o  out  addr_width  bus address.
- wb_cyc_o, wb_stb_o  out  1 each  bus cycle and strobe, always asserted together.
- wb_we_o  out  1  constant 0.
- wb_sel_o  out  4  constant 4'hf.
- wb_cti_o  out  3  cycle type.
- wb_bte_o  out  2  constant 2'b00 (linear).
- wb_dat_i  in  32  read data.
- wb_ack_i, wb_err_i  in  1 each  slave termination.

## Operation
- States: IDLE, WAIT_SPACE, BURST, GAP.
- IDLE, on accept:
  - Latch the address as a word address and the remaining count as rem.
  - Clear err and set busy.
  - If cmd_len == 0, clear busy next cycle and stay in IDLE; no bus cycle and no stream word are produced.
  - Otherwise go to WAIT_SPACE.
- WAIT_SPACE:
  - beats = min(rem, burst_len).
  - When FIFO free count ≥ beats, assert cyc/stb with wb_adr_o = current address and go to BURST.
- BURST:
  - Every beat except the burst's last uses CTI 3'b010; the last beat uses 3'b111.
  - A 1-beat burst drives 3'b111 throughout.
  - On each wb_ack_i:
    - Push wb_dat_i into the FIFO, tagging last if rem == 1.
    - Address += 4, wrapping modulo 2^addr_width.
    - rem -= 1.
    - Update CTI for the next beat.
  - On ack of the burst's final beat, deassert cyc/stb. If rem == 0, clear busy and go to IDLE; otherwise go to GAP.
- GAP: one cycle with cyc low, then WAIT_SPACE.
- Error:
  - wb_err_i (with or without ack) ends the cycle: cyc/stb low next cycle, err set, busy cleared, rem discarded, state IDLE.
  - The erroring beat's data is not pushed.
  - Words already in the FIFO still drain; dat_last is not produced for an aborted command.
- FIFO: a simultaneous push and pop in the same cycle is legal and keeps the count unchanged. The push-side free check guarantees no overflow.
- Reset values:
  - Bus outputs: wb_cyc_o, wb_stb_o, wb_we_o = 0; wb_adr_o = 0; wb_cti_o = 3'b000; wb_bte_o = 2'b00; wb_sel_o = 4'hf.
  - Status and stream: dat_valid, dat_last, busy, err = 0; dat_o = 0.
  - cmd_ready = 1; FIFO empty; state IDLE.
- Reset mid-burst drops cyc immediately (async) and flushes the FIFO.

## Timing
- All outputs are registered.
- Accept at edge N: cyc/stb high from cycle N+1 at the earliest (WAIT_SPACE is passed in one cycle when space is available).
- Ack sampled at edge M: data visible on dat_o with dat_valid at M+1; new wb_adr_o and wb_cti_o valid at M+1.
- The bus transfer for a burst completes one beat per cycle against a slave that acks every cycle.
- Bursts are separated by exactly one idle bus cycle when FIFO space permits.
- cmd_ready returns high the cycle after busy falls.

## Test plan
- cmd_adr=0x100, len=8, burst_len=4, slave acks every cycle, dat_ready=1:
  - Two bursts with CTI 010,010,010,111 each and addresses 0x100..0x11c.
  - cyc low exactly one cycle between bursts.
  - 8 words in order; dat_last on word 8 only.
- len=5, burst_len=4 → a 4-beat burst, then a single beat at 0x110 with CTI 111; dat_last on word 5.
- len=16, dat_ready=0 for 20 cycles, fifo_depth=8:
  - Exactly two bursts complete, then the master holds in WAIT_SPACE with cyc low and no overflow.
  - Releasing dat_ready delivers all 16 words in order.
- len=0 → no cyc assertion; busy high one cycle; no stream word; cmd_ready high again the next cycle.
- len=6, wb_err_i on beat 3:
  - Two words are streamed, err=1, busy=0, no dat_last, cyc low next cycle.
  - A new command clears err.
- cmd_adr=0xfffffff8, len=4 → addresses 0xfffffff8, 0xfffffffc, 0x0, 0x4; wb_rst pulsed mid-burst returns all outputs to reset values with the FIFO empty.

Source files
------------

// File: rtl/wb_burst_reader.sv
// Wishbone B3 burst read master: fetches cmd_len words with linear incrementing bursts
// and streams them out through a FIFO that always has room for the whole burst.
module wb_burst_reader #(
    parameter int addr_width = 32,
    parameter int len_width  = 16,
    parameter int burst_len  = 4,
    parameter int fifo_depth = 8
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [addr_width-1:0] cmd_adr,
    input  logic [len_width-1:0]  cmd_len,
    output logic                  dat_valid,
    input  logic                  dat_ready,
    output logic [31:0]           dat_o,
    output logic                  dat_last,
    output logic                  busy,
    output logic                  err,
    output logic [addr_width-1:0] wb_adr_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [3:0]            wb_sel_o,
    output logic [2:0]            wb_cti_o,
    output logic [1:0]            wb_bte_o,
    input  logic [31:0]           wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i
);

    localparam int PW = $clog2(fifo_depth);
    localparam int CW = PW + 1;
    localparam int AW = addr_width - 2;

    localparam logic [len_width-1:0] LEN_ONE  = len_width'(1);
    localparam logic [len_width-1:0] LEN_ZERO = len_width'(0);
    localparam logic [AW-1:0]        ADR_ONE  = AW'(1);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]        CNT_TWO  = CW'(2);
    localparam logic [PW-1:0]        PTR_ONE  = PW'(1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_SPACE = 2'd1,
        S_BURST      = 2'd2,
        S_GAP        = 2'd3
    } state_t;

    state_t                 r_state, w_state_next;
    logic [AW-1:0]          r_adr, w_adr_next;
    logic [len_width-1:0]   r_rem, w_rem_next;
    logic [CW-1:0]          r_beats_left, w_beats_left_next;
    logic                   r_cyc, w_cyc_next;
    logic [2:0]             r_cti, w_cti_next;
    logic                   r_busy, w_busy_next;
    logic                   r_err, w_err_next;
    logic                   r_cmd_ready, w_cmd_ready_next;

    logic [31:0]            r_mem [fifo_depth];
    logic [fifo_depth-1:0]  r_mem_last;
    logic [PW-1:0]          r_wptr, r_rptr;
    logic [CW-1:0]          r_count, w_count_next;
    logic                   r_valid;

    logic                   w_accept, w_push, w_pop, w_space_ok;
    logic [CW-1:0]          w_beats, w_free;
    logic [1:0]             w_unused_adr_bits;

    assign w_unused_adr_bits = cmd_adr[1:0];
    assign w_accept   = cmd_valid & r_cmd_ready;
    assign w_push     = (r_state == S_BURST) & wb_ack_i & ~wb_err_i;
    assign w_pop      = r_valid & dat_ready;
    assign w_beats    = (r_rem < len_width'(burst_len)) ? CW'(r_rem) : CW'(burst_len);
    assign w_free     = CW'(fifo_depth) - r_count;
    assign w_space_ok = (w_free >= w_beats);

    // Next-state and next-output logic for the bus-side controller.
    always_comb begin
        w_state_next      = r_state;
        w_adr_next        = r_adr;
        w_rem_next        = r_rem;
        w_beats_left_next = r_beats_left;
        w_cyc_next        = r_cyc;
        w_cti_next        = r_cti;
        w_busy_next       = r_busy;
        w_err_next        = r_err;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_adr_next  = cmd_adr[addr_width-1:2];
                    w_rem_next  = cmd_len;
                    w_err_next  = 1'b0;
                    w_busy_next = 1'b1;
                    if (cmd_len == LEN_ZERO) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_WAIT_SPACE;
                    end
                end else begin
                    w_busy_next = 1'b0;
                end
            end
            // GAP already holds cyc low for its one cycle, so it may launch the next burst directly.
            S_WAIT_SPACE, S_GAP: begin
                if (w_space_ok) begin
                    w_state_next      = S_BURST;
                    w_cyc_next        = 1'b1;
                    w_beats_left_next = w_beats;
                    w_cti_next        = (w_beats == CNT_ONE) ? 3'b111 : 3'b010;
                end else begin
                    w_state_next = S_WAIT_SPACE;
                end
            end
            S_BURST: begin
                if (wb_err_i) begin
                    w_state_next = S_IDLE;
                    w_cyc_next   = 1'b0;
                    w_cti_next   = 3'b000;
                    w_err_next   = 1'b1;
                    w_busy_next  = 1'b0;
                    w_rem_next   = LEN_ZERO;
                end else if (wb_ack_i) begin
                    w_adr_next        = r_adr + ADR_ONE;
                    w_rem_next        = r_rem - LEN_ONE;
                    w_beats_left_next = r_beats_left - CNT_ONE;
                    if (r_beats_left == CNT_ONE) begin
                        w_cyc_next = 1'b0;
                        w_cti_next = 3'b000;
                        if (r_rem == LEN_ONE) begin
                            w_state_next = S_IDLE;
                            w_busy_next  = 1'b0;
                        end else begin
                            w_state_next = S_GAP;
                        end
                    end else begin
                        w_cti_next = (r_beats_left == CNT_TWO) ? 3'b111 : 3'b010;
                    end
                end else begin
                    w_state_next = S_BURST;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cyc_next   = 1'b0;
                w_cti_next   = 3'b000;
                w_busy_next  = 1'b0;
            end
        endcase
        w_cmd_ready_next = (w_state_next == S_IDLE) & ~w_busy_next;
    end

    // Controller state and registered bus/status outputs.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            r_state      <= S_IDLE;
            r_adr        <= '0;
            r_rem        <= '0;
            r_beats_left <= '0;
            r_cyc        <= 1'b0;
            r_cti        <= 3'b000;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_cmd_ready  <= 1'b1;
        end else begin
            r_state      <= w_state_next;
            r_adr        <= w_adr_next;
            r_rem        <= w_rem_next;
            r_beats_left <= w_beats_left_next;
            r_cyc        <= w_cyc_next;
            r_cti        <= w_cti_next;
            r_busy       <= w_busy_next;
            r_err        <= w_err_next;
            r_cmd_ready  <= w_cmd_ready_next;
        end
    end

    // FIFO occupancy after this cycle's push/pop.
    always_comb begin
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_ONE;
            2'b01:   w_count_next = r_count - CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    // Output FIFO storage and pointers; the last tag travels with each word.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            for (int i = 0; i < fifo_depth; i++) begin
                r_mem[i] <= 32'h0000_0000;
            end
            r_mem_last <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr]      <= wb_dat_i;
                r_mem_last[r_wptr] <= (r_rem == LEN_ONE);
                r_wptr             <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            r_count <= w_count_next;
            r_valid <= (w_count_next != '0);
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign err       = r_err;
    assign dat_valid = r_valid;
    assign dat_o     = r_mem[r_rptr];
    assign dat_last  = r_valid & r_mem_last[r_rptr];
    assign wb_adr_o  = {r_adr, 2'b00};
    assign wb_cyc_o  = r_cyc;
    assign wb_stb_o  = r_cyc;
    assign wb_we_o   = 1'b0;
    assign wb_sel_o  = 4'hf;
    assign wb_cti_o  = r_cti;
    assign wb_bte_o  = 2'b00;

endmodule

// File: tb/tb_wb_burst_reader.sv
// Directed bench for wb_burst_reader: a slave that acks every cycle (with optional error
// injection at one address) and monitors that log bus beats and stream words.
module tb_wb_burst_reader;

    localparam logic [31:0] DMASK = 32'hA5A5_0000;

    logic        wb_clk = 1'b0;
    logic        wb_rst;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_adr;
    logic [15:0] cmd_len;
    logic        dat_valid, dat_ready, dat_last, busy, err;
    logic [31:0] dat_o, wb_adr_o, wb_dat_i;
    logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, wb_err_i;
    logic [3:0]  wb_sel_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;

    logic        err_en;
    logic [31:0] err_adr;
    logic        w_err_hit;

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int cyc_high = 0;
    logic [31:0] bus_adr[$];
    logic [2:0]  bus_cti[$];
    int          bus_cyc[$];
    logic [31:0] st_dat[$];
    logic        st_last[$];

    always #5 wb_clk = ~wb_clk;

    wb_burst_reader dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_adr(cmd_adr), .cmd_len(cmd_len),
        .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_o(dat_o), .dat_last(dat_last),
        .busy(busy), .err(err),
        .wb_adr_o(wb_adr_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    assign w_err_hit = wb_cyc_o & wb_stb_o & err_en & (wb_adr_o == err_adr);
    assign wb_err_i  = w_err_hit;
    assign wb_ack_i  = wb_cyc_o & wb_stb_o & ~w_err_hit;
    assign wb_dat_i  = wb_adr_o ^ DMASK;

    always @(negedge wb_clk) begin
        cyc_n <= cyc_n + 1;
        if (wb_cyc_o) cyc_high <= cyc_high + 1;
        if (wb_cyc_o && wb_ack_i) begin
            bus_adr.push_back(wb_adr_o);
            bus_cti.push_back(wb_cti_o);
            bus_cyc.push_back(cyc_n);
        end
        if (dat_valid && dat_ready) begin
            st_dat.push_back(dat_o);
            st_last.push_back(dat_last);
        end
    end

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic clear_mon();
        bus_adr.delete(); bus_cti.delete(); bus_cyc.delete();
        st_dat.delete(); st_last.delete();
    endtask

    task automatic send_cmd(input logic [31:0] a, input logic [15:0] n);
        int t = 0;
        while (!cmd_ready && t < 100) begin tick(); t++; end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL cmd_ready_wait: got %b expected 1", cmd_ready);
        end
        cmd_adr = a; cmd_len = n; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int t = 0;
        while ((busy || dat_valid) && t < budget) begin tick(); t++; end
        checks++;
        if (busy !== 1'b0 || dat_valid !== 1'b0) begin
            errors++; $display("FAIL %s_timeout: busy=%b dat_valid=%b expected 0 0", name, busy, dat_valid);
        end
    endtask

    task automatic test_reset();
        logic [16:0] got, exp;
        wb_rst = 1'b1; cmd_valid = 1'b0; cmd_adr = '0; cmd_len = '0;
        dat_ready = 1'b0; err_en = 1'b0; err_adr = '0;
        repeat (3) tick();
        wb_rst = 1'b0;
        tick();
        got = {cmd_ready, wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o, wb_bte_o, wb_sel_o, dat_valid, dat_last, busy, err};
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 4'hf, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_ctrl: got %h expected %h", got, exp); end
        checks++;
        if (wb_adr_o !== 32'h0) begin errors++; $display("FAIL reset_adr: got %h expected 0", wb_adr_o); end
        checks++;
        if (dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h expected 0", dat_o); end
    endtask

    // Full linear command with an always-ready consumer; checks beats, CTI, gaps and stream.
    task automatic test_linear(input logic [31:0] a, input int n, input string name);
        logic [2:0]  ecti;
        logic [31:0] eadr;
        int p, bs;
        clear_mon();
        dat_ready = 1'b1;
        send_cmd(a, 16'(n));
        wait_idle(200, name);
        checks++;
        if (bus_adr.size() != n) begin errors++; $display("FAIL %s_beats: got %0d expected %0d", name, bus_adr.size(), n); end
        for (int i = 0; i < n && i < bus_adr.size(); i++) begin
            p = i % 4;
            bs = (n - (i - p) < 4) ? n - (i - p) : 4;
            ecti = (p == bs - 1) ? 3'b111 : 3'b010;
            eadr = a + 32'(4 * i);
            checks++;
            if (bus_adr[i] !== eadr) begin errors++; $display("FAIL %s_adr%0d: got %h expected %h", name, i, bus_adr[i], eadr); end
            checks++;
            if (bus_cti[i] !== ecti) begin errors++; $display("FAIL %s_cti%0d: got %b expected %b", name, i, bus_cti[i], ecti); end
            if (i > 0) begin
                checks++;
                if (bus_cyc[i] - bus_cyc[i-1] != ((p == 0) ? 2 : 1)) begin
                    errors++; $display("FAIL %s_spacing%0d: got %0d expected %0d", name, i, bus_cyc[i] - bus_cyc[i-1], (p == 0) ? 2 : 1);
                end
            end
        end
        checks++;
        if (st_dat.size() != n) begin errors++; $display("FAIL %s_words: got %0d expected %0d", name, st_dat.size(), n); end
        for (int i = 0; i < n && i < st_dat.size(); i++) begin
            eadr = (a + 32'(4 * i)) ^ DMASK;
            checks++;
            if (st_dat[i] !== eadr) begin errors++; $display("FAIL %s_data%0d: got %h expected %h", name, i, st_dat[i], eadr); end
            checks++;
            if (st_last[i] !== (i == n - 1)) begin errors++; $display("FAIL %s_last%0d: got %b expected %b", name, i, st_last[i], (i == n - 1)); end
        end
    endtask

    task automatic test_zero_len();
        int c0;
        clear_mon();
        c0 = cyc_high;
        send_cmd(32'h500, 16'd0);
        checks++;
        if ({busy, cmd_ready} !== 2'b10) begin errors++; $display("FAIL zero_accept: busy,cmd_ready got %b expected 10", {busy, cmd_ready}); end
        tick();
        checks++;
        if ({busy, cmd_ready} !== 2'b01) begin errors++; $display("FAIL zero_done: busy,cmd_ready got %b expected 01", {busy, cmd_ready}); end
        repeat (4) tick();
        checks++;
        if (cyc_high != c0) begin errors++; $display("FAIL zero_cyc: got %0d cyc cycles expected 0", cyc_high - c0); end
        checks++;
        if (st_dat.size() != 0) begin errors++; $display("FAIL zero_words: got %0d expected 0", st_dat.size()); end
    endtask

    task automatic test_backpressure();
        logic [31:0] e;
        clear_mon();
        dat_ready = 1'b0;
        send_cmd(32'h400, 16'd16);
        repeat (20) tick();
        checks++;
        if (bus_adr.size() != 8) begin errors++; $display("FAIL bp_held_beats: got %0d expected 8", bus_adr.size()); end
        checks++;
        if ({wb_cyc_o, busy, dat_valid} !== 3'b011) begin errors++; $display("FAIL bp_hold: cyc,busy,valid got %b expected 011", {wb_cyc_o, busy, dat_valid}); end
        dat_ready = 1'b1;
        wait_idle(300, "bp");
        checks++;
        if (st_dat.size() != 16) begin errors++; $display("FAIL bp_words: got %0d expected 16", st_dat.size()); end
        for (int i = 0; i < 16 && i < st_dat.size(); i++) begin
            e = (32'h400 + 32'(4 * i)) ^ DMASK;
            checks++;
            if (st_dat[i] !== e || st_last[i] !== (i == 15)) begin
                errors++; $display("FAIL bp_word%0d: got %h/%b expected %h/%b", i, st_dat[i], st_last[i], e, (i == 15));
            end
        end
    endtask

    task automatic test_error();
        int t = 0;
        clear_mon();
        dat_ready = 1'b1; err_adr = 32'h608; err_en = 1'b1;
        send_cmd(32'h600, 16'd6);
        while (!wb_err_i && t < 50) begin tick(); t++; end
        checks++;
        if (wb_err_i !== 1'b1) begin errors++; $display("FAIL err_seen: got %b expected 1", wb_err_i); end
        tick();
        checks++;
        if ({wb_cyc_o, wb_stb_o, busy, err, cmd_ready} !== 5'b00011) begin
            errors++; $display("FAIL err_after: cyc,stb,busy,err,rdy got %b expected 00011", {wb_cyc_o, wb_stb_o, busy, err, cmd_ready});
        end
        repeat (4) tick();
        checks++;
        if (st_dat.size() != 2 || bus_adr.size() != 2) begin
            errors++; $display("FAIL err_counts: words %0d beats %0d expected 2 2", st_dat.size(), bus_adr.size());
        end
        for (int i = 0; i < 2 && i < st_dat.size(); i++) begin
            checks++;
            if (st_dat[i] !== ((32'h600 + 32'(4 * i)) ^ DMASK) || st_last[i] !== 1'b0) begin
                errors++; $display("FAIL err_word%0d: got %h/%b expected %h/0", i, st_dat[i], st_last[i], (32'h600 + 32'(4 * i)) ^ DMASK);
            end
        end
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err); end
        err_en = 1'b0;
        send_cmd(32'h700, 16'd1);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", err); end
        wait_idle(50, "err_next");
    endtask

    task automatic test_reset_mid_burst();
        logic [16:0] got, exp;
        int t = 0;
        clear_mon();
        dat_ready = 1'b0;
        send_cmd(32'h800, 16'd16);
        while (bus_adr.size() < 2 && t < 50) begin tick(); t++; end
        checks++;
        if (wb_cyc_o !== 1'b1) begin errors++; $display("FAIL rst_pre_cyc: got %b expected 1", wb_cyc_o); end
        wb_rst = 1'b1;
        #1;
        got = {cmd_ready, wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o, wb_bte_o, wb_sel_o, dat_valid, dat_last, busy, err};
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 4'hf, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL rst_mid_ctrl: got %h expected %h", got, exp); end
        checks++;
        if (wb_adr_o !== 32'h0 || dat_o !== 32'h0) begin errors++; $display("FAIL rst_mid_adr_dat: got %h/%h expected 0/0", wb_adr_o, dat_o); end
        tick();
        wb_rst = 1'b0;
        repeat (2) tick();
        checks++;
        if ({wb_cyc_o, dat_valid, busy, cmd_ready} !== 4'b0001) begin
            errors++; $display("FAIL rst_after: cyc,valid,busy,rdy got %b expected 0001", {wb_cyc_o, dat_valid, busy, cmd_ready});
        end
    endtask

    initial begin
        test_reset();
        test_linear(32'h100, 8, "two_bursts");
        test_linear(32'h100, 5, "short_tail");
        test_zero_len();
        test_backpressure();
        test_error();
        test_linear(32'hffff_fff8, 4, "wrap");
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
